i_pd_controller: RTL and testbench

//  Discrete I-PD servo controller: integral action on error (referencia - y),

---
 rtl/i_pd_controller.sv | 162 ++++++++++++++++
 tb/tb_i_pd_controller.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/i_pd_controller.sv
// I-PD servo controller: integral action on (referencia - y), proportional and
// derivative action on the measured output y only. One update per rising edge
// of enable, sequenced through a small FSM. Result held on IPD.
module i_pd_controller #(
    parameter int                     W    = 18,
    parameter int                     FRAC = 10,
    parameter logic signed [W-1:0]    KP   = 18'sd1024,
    parameter logic signed [W-1:0]    KI   = 18'sd256,
    parameter logic signed [W-1:0]    KD   = 18'sd512
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic signed [W-1:0] referencia,
    input  logic signed [W-1:0] y,
    output logic signed [W-1:0] IPD
);

    // Width of a full signed product, and of the common saturation input.
    localparam int PW = 2 * W;
    localparam int SW = PW + 2;

    localparam logic signed [SW-1:0] MAXW = {{(SW-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [SW-1:0] MINW = {{(SW-W+1){1'b1}}, {(W-1){1'b0}}};

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ERR  = 3'd1,
        ST_MUL  = 3'd2,
        ST_ACC  = 3'd3,
        ST_OUT  = 3'd4,
        ST_WAIT = 3'd5
    } state_t;

    // Clamp a wide signed value into the W-bit two's complement range.
    function automatic logic signed [W-1:0] sat(input logic signed [SW-1:0] v);
        logic signed [W-1:0] res;
        if (v > MAXW) begin
            res = MAXW[W-1:0];
        end else if (v < MINW) begin
            res = MINW[W-1:0];
        end else begin
            res = v[W-1:0];
        end
        return res;
    endfunction

    // Fixed-point multiply: full product, arithmetic shift (floor), saturate.
    function automatic logic signed [W-1:0] mul_sat(input logic signed [W-1:0] a,
                                                    input logic signed [W-1:0] b);
        logic signed [PW-1:0] p;
        logic signed [PW-1:0] sh;
        logic signed [SW-1:0] wide;
        p    = $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b});
        sh   = p >>> FRAC;
        wide = {{2{sh[PW-1]}}, sh};
        return sat(wide);
    endfunction

    state_t              state_r;
    logic                enable_d_r;
    logic signed [W-1:0] r_lat_r;
    logic signed [W-1:0] y_lat_r;
    logic signed [W-1:0] y_prev_r;
    logic signed [W-1:0] e_r;
    logic signed [W-1:0] dy_r;
    logic signed [W-1:0] pi_r;
    logic signed [W-1:0] pp_r;
    logic signed [W-1:0] pd_r;
    logic signed [W-1:0] integ_r;

    logic signed [W:0]   err_wide_s;
    logic signed [W:0]   dy_wide_s;
    logic signed [W:0]   integ_wide_s;
    logic signed [W+1:0] out_wide_s;
    logic signed [W-1:0] err_s;
    logic signed [W-1:0] dy_s;
    logic signed [W-1:0] pi_s;
    logic signed [W-1:0] pp_s;
    logic signed [W-1:0] pd_s;
    logic signed [W-1:0] integ_next_s;
    logic signed [W-1:0] ipd_next_s;

    // Datapath for every stage, computed from registered operands.
    always_comb begin
        err_wide_s   = {r_lat_r[W-1], r_lat_r} - {y_lat_r[W-1], y_lat_r};
        dy_wide_s    = {y_lat_r[W-1], y_lat_r} - {y_prev_r[W-1], y_prev_r};
        err_s        = sat({{(SW-W-1){err_wide_s[W]}}, err_wide_s});
        dy_s         = sat({{(SW-W-1){dy_wide_s[W]}}, dy_wide_s});
        pi_s         = mul_sat(KI, e_r);
        pp_s         = mul_sat(KP, y_lat_r);
        pd_s         = mul_sat(KD, dy_r);
        integ_wide_s = {integ_r[W-1], integ_r} + {pi_r[W-1], pi_r};
        integ_next_s = sat({{(SW-W-1){integ_wide_s[W]}}, integ_wide_s});
        out_wide_s   = {{2{integ_r[W-1]}}, integ_r}
                     - {{2{pp_r[W-1]}}, pp_r}
                     - {{2{pd_r[W-1]}}, pd_r};
        ipd_next_s   = sat({{(SW-W-2){out_wide_s[W+1]}}, out_wide_s});
    end

    // Sequencer and all state: capture, one stage per clock, output hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            enable_d_r <= 1'b0;
            r_lat_r    <= '0;
            y_lat_r    <= '0;
            y_prev_r   <= '0;
            e_r        <= '0;
            dy_r       <= '0;
            pi_r       <= '0;
            pp_r       <= '0;
            pd_r       <= '0;
            integ_r    <= '0;
            IPD        <= '0;
        end else begin
            enable_d_r <= enable;
            case (state_r)
                ST_IDLE: begin
                    if (enable && !enable_d_r) begin
                        r_lat_r <= referencia;
                        y_lat_r <= y;
                        state_r <= ST_ERR;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ERR: begin
                    e_r     <= err_s;
                    dy_r    <= dy_s;
                    state_r <= ST_MUL;
                end
                ST_MUL: begin
                    pi_r    <= pi_s;
                    pp_r    <= pp_s;
                    pd_r    <= pd_s;
                    state_r <= ST_ACC;
                end
                ST_ACC: begin
                    integ_r <= integ_next_s;
                    state_r <= ST_OUT;
                end
                ST_OUT: begin
                    IPD      <= ipd_next_s;
                    y_prev_r <= y_lat_r;
                    state_r  <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (enable) begin
                        state_r <= ST_WAIT;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i_pd_controller.sv
// Directed bench for i_pd_controller: a table of per-update vectors with
// hand-computed outputs, plus sequences for latency, hold, retrigger and reset.
module tb_i_pd_controller;

    logic               clk;
    logic               reset;
    logic               enable;
    logic signed [17:0] referencia;
    logic signed [17:0] y;
    logic signed [17:0] IPD;

    int checks_total;
    int checks_passed;

    typedef struct {
        logic               do_rst;
        logic signed [17:0] r;
        logic signed [17:0] yv;
        logic signed [17:0] exp_ipd;
    } vec_t;

    vec_t vecs[16];

    i_pd_controller dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .referencia (referencia),
        .y          (y),
        .IPD        (IPD)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic signed [17:0] act,
                         input logic signed [17:0] exp_v);
        checks_total = checks_total + 1;
        if (act === exp_v) begin
            checks_passed = checks_passed + 1;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
        end
    endtask

    // Asynchronous reset between edges; IPD must clear without a clock.
    task automatic do_reset();
        enable = 1'b0;
        #1 reset = 1'b1;
        #1 check("reset_ipd", IPD, 18'sd0);
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // One enable pulse; called at posedge+1, returns at posedge+1.
    task automatic pulse(input logic signed [17:0] r, input logic signed [17:0] yv,
                         input int hi, input int lo);
        referencia = r;
        y          = yv;
        enable     = 1'b1;
        repeat (hi) @(posedge clk);
        #1 enable = 1'b0;
        repeat (lo) @(posedge clk);
        #1;
    endtask

    initial begin
        checks_total  = 0;
        checks_passed = 0;
        reset         = 1'b1;
        enable        = 1'b0;
        referencia    = 18'sd0;
        y             = 18'sd0;

        // Step: integrator ramps by KI*e = 256 per update.
        vecs[0]  = '{1'b1, 18'sd1024, 18'sd0, 18'sd256};
        vecs[1]  = '{1'b0, 18'sd1024, 18'sd0, 18'sd512};
        vecs[2]  = '{1'b0, 18'sd1024, 18'sd0, 18'sd768};
        vecs[3]  = '{1'b0, 18'sd1024, 18'sd0, 18'sd1024};
        // P+D kick: -256 - 1024 - 512, then dy = 0.
        vecs[4]  = '{1'b1, 18'sd0, 18'sd1024, -18'sd1792};
        vecs[5]  = '{1'b0, 18'sd0, 18'sd1024, -18'sd1536};
        // Positive saturation; integ 32767,65534,98301,131068,131071.
        vecs[6]  = '{1'b1, 18'sd131071, -18'sd131072, 18'sd131071};
        vecs[7]  = '{1'b0, 18'sd131071, -18'sd131072, 18'sd131071};
        vecs[8]  = '{1'b0, 18'sd131071, -18'sd131072, 18'sd131071};
        vecs[9]  = '{1'b0, 18'sd131071, -18'sd131072, 18'sd131071};
        vecs[10] = '{1'b0, 18'sd131071, -18'sd131072, 18'sd131071};
        // Expose integ: dy sat to 131071, pd 65535 -> 65536; then integ alone.
        vecs[11] = '{1'b0, 18'sd0, 18'sd0, 18'sd65536};
        vecs[12] = '{1'b0, 18'sd0, 18'sd0, 18'sd131071};
        // Floor rounding: pi = -1, pp = 1, pd = floor(0.5) = 0.
        vecs[13] = '{1'b1, 18'sd0, 18'sd1, -18'sd2};
        vecs[14] = '{1'b0, 18'sd0, 18'sd1, -18'sd3};
        // Negative saturation.
        vecs[15] = '{1'b1, -18'sd131072, 18'sd131071, -18'sd131072};

        repeat (2) @(posedge clk);
        #1 check("por_ipd", IPD, 18'sd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 16; i++) begin
            if (vecs[i].do_rst) do_reset();
            pulse(vecs[i].r, vecs[i].yv, 5, 3);
            check($sformatf("vec%0d", i), IPD, vecs[i].exp_ipd);
        end

        // Latency, input isolation after capture, hold for 50 cycles.
        do_reset();
        referencia = 18'sd1024;
        y          = 18'sd0;
        enable     = 1'b1;
        @(posedge clk);
        #1 referencia = -18'sd5000;
        y = 18'sd777;
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk);
            #1 check($sformatf("latency_e%0d", i), IPD, 18'sd0);
        end
        @(posedge clk);
        #1 check("latency_e4", IPD, 18'sd256);
        for (int i = 5; i < 50; i++) begin
            @(posedge clk);
            #1 check("hold", IPD, 18'sd256);
        end
        enable = 1'b0;
        repeat (3) @(posedge clk);
        #1 check("hold_after", IPD, 18'sd256);
        referencia = 18'sd1024;
        y          = 18'sd0;
        enable     = 1'b1;
        @(posedge clk);
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk);
            #1 check("stable_to_next", IPD, 18'sd256);
        end
        @(posedge clk);
        #1 check("second_update", IPD, 18'sd512);
        enable = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // One-cycle pulse, plus a new rising edge during the update.
        do_reset();
        referencia = 18'sd1024;
        y          = 18'sd0;
        enable     = 1'b1;
        @(posedge clk);
        #1 enable = 1'b0;
        @(posedge clk);
        #1 enable = 1'b1;
        @(posedge clk);
        #1 enable = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 check("short_pulse", IPD, 18'sd256);
        repeat (6) @(posedge clk);
        #1 check("no_retrigger", IPD, 18'sd256);
        pulse(18'sd1024, 18'sd0, 5, 3);
        check("after_retrigger", IPD, 18'sd512);

        // Reset in the middle of an update, then a fresh first sample.
        referencia = 18'sd1024;
        y          = 18'sd0;
        enable     = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        enable = 1'b0;
        #1 check("reset_async", IPD, 18'sd0);
        @(posedge clk);
        #1 check("reset_held", IPD, 18'sd0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        pulse(18'sd0, 18'sd1024, 5, 3);
        check("post_reset_first", IPD, -18'sd1792);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
